// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type, LFSR taps and sizing helpers for the pipe field controller
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Feedback taps at bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

    function automatic int respawn_pos(input int end_pos, input int n_pipes, input int spacing);
        return end_pos + n_pipes * spacing;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int bits_for(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// rtl/pipe_lfsr16.sv - seedable free-running 16-bit Fibonacci LFSR, low bits exposed
module pipe_lfsr16
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/pipe_field_ctrl.sv
// rtl/pipe_field_ctrl.sv - multi-channel scrolling pipe field with respawn, pass detection and score
module pipe_field_ctrl
    import pipe_pkg::*;
#(
    parameter int          N_PIPES     = 3,
    parameter int          H_TOT       = 800,
    parameter int          RST_POS     = 0,
    parameter int          START_POS   = 640,
    parameter int          END_POS     = 0,
    parameter int          SPACING     = 267,
    parameter int          BIRD_X      = 100,
    parameter int          GAP_MIN     = 100,
    parameter int          GAP_BITS    = 8,
    parameter int          START_SPEED = 800_000,
    parameter int          MAX_SPEED   = 100_000,
    parameter int          SPEED_INC   = 10_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          SCORE_W     = 14,
    localparam int RESPAWN = respawn_pos(END_POS, N_PIPES, SPACING),
    localparam int P_W     = bits_for(max_int(START_POS + (N_PIPES - 1) * SPACING, RESPAWN)),
    localparam int S_W     = bits_for(START_SPEED),
    localparam int Y_W     = bits_for(GAP_MIN + 2**GAP_BITS - 1)
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic                     iStart,
    input  logic                     iStop,
    input  logic                     iRun,
    input  logic                     iSpeedInc,
    output logic [N_PIPES*P_W-1:0]   oPos,
    output logic [N_PIPES*Y_W-1:0]   oGapY,
    output logic [N_PIPES-1:0]       oActive,
    output logic [N_PIPES-1:0]       oRespawn,
    output logic                     oPass,
    output logic [SCORE_W-1:0]       oScore,
    output logic                     oRunning
);

    localparam int               IDX_W        = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_PIPES - 1);
    localparam logic [S_W-1:0]   START_PERIOD = S_W'(START_SPEED);
    localparam logic [S_W-1:0]   MIN_PERIOD   = S_W'(MAX_SPEED);
    localparam logic [S_W-1:0]   PERIOD_STEP  = S_W'(SPEED_INC);
    localparam logic [31:0]      STEP_FLOOR   = 32'(MAX_SPEED + SPEED_INC);
    localparam logic [P_W-1:0]   POS_RST      = P_W'(RST_POS);
    localparam logic [P_W-1:0]   POS_END      = P_W'(END_POS);
    localparam logic [P_W-1:0]   POS_RESPAWN  = P_W'(RESPAWN);
    localparam logic [P_W-1:0]   POS_BIRD     = P_W'(BIRD_X);

    if (START_POS >= H_TOT || SPACING <= 0 || BIRD_X <= END_POS || BIRD_X > START_POS ||
        LFSR_SEED == 16'h0 || N_PIPES < 1 || MAX_SPEED < 1) begin : g_bad_cfg
        $error("pipe_field_ctrl: illegal parameter combination");
    end

    state_t             state, next_state;
    logic [IDX_W-1:0]   load_idx;
    logic [S_W-1:0]     period, cnt;
    logic [SCORE_W-1:0] score;
    logic               running, pass;
    logic               stop_act, start_act, load_en, tick;
    logic [GAP_BITS-1:0] rnd;
    logic [Y_W-1:0]     gap_new;
    logic [N_PIPES-1:0] passed;

    pipe_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (GAP_BITS)
    ) u_lfsr (
        .clk   (iClk),
        .rst_n (iRstN),
        .value (rnd)
    );

    // Stop outranks start; in IDLE there is nothing to freeze so stop is dropped
    assign stop_act  = iStop && (state != ST_IDLE);
    assign start_act = iStart && !stop_act;
    assign load_en   = (state == ST_LOAD) && !stop_act && !start_act;
    assign tick      = running && iRun && !stop_act && !start_act && (cnt >= period - S_W'(1));
    assign gap_new   = Y_W'(GAP_MIN) + Y_W'(rnd);

    always_comb begin
        next_state = state;
        if (stop_act) begin
            next_state = ST_HALT;
        end else if (start_act) begin
            next_state = ST_LOAD;
        end else if (load_en && load_idx == LAST_IDX) begin
            next_state = ST_RUN;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= ST_IDLE;
            load_idx <= '0;
            period   <= START_PERIOD;
            cnt      <= '0;
            score    <= '0;
            pass     <= 1'b0;
            running  <= 1'b0;
        end else begin
            state   <= next_state;
            // Scrolling starts one cycle after the last pipe is loaded
            running <= (state == ST_RUN) && (next_state == ST_RUN);
            pass    <= |passed;

            if (start_act) begin
                load_idx <= '0;
            end else if (load_en) begin
                load_idx <= load_idx + IDX_W'(1);
            end

            if (start_act) begin
                period <= START_PERIOD;
            end else if (iSpeedInc) begin
                period <= (32'(period) >= STEP_FLOOR) ? period - PERIOD_STEP : MIN_PERIOD;
            end

            if (start_act || tick) begin
                cnt <= '0;
            end else if (running && iRun && !stop_act) begin
                cnt <= cnt + S_W'(1);
            end

            if (start_act) begin
                score <= '0;
            end else if (|passed && score != '1) begin
                score <= score + SCORE_W'(1);
            end
        end
    end

    for (genvar k = 0; k < N_PIPES; k++) begin : g_pipe
        localparam logic [P_W-1:0] LOAD_POS = P_W'(START_POS + k * SPACING);

        logic [P_W-1:0] pos;
        logic [Y_W-1:0] gap;
        logic           active;
        logic           respawn;

        always_ff @(posedge iClk or negedge iRstN) begin
            if (!iRstN) begin
                pos     <= POS_RST;
                gap     <= '0;
                active  <= 1'b0;
                respawn <= 1'b0;
            end else begin
                respawn <= 1'b0;
                if (start_act) begin
                    active <= 1'b0;
                end else if (load_en && load_idx == IDX_W'(k)) begin
                    pos    <= LOAD_POS;
                    gap    <= gap_new;
                    active <= 1'b1;
                end else if (tick && active) begin
                    if (pos == POS_END) begin
                        pos     <= POS_RESPAWN;
                        gap     <= gap_new;
                        respawn <= 1'b1;
                    end else begin
                        pos <= pos - P_W'(1);
                    end
                end
            end
        end

        assign passed[k]             = tick && active && (pos == POS_BIRD);
        assign oPos[k*P_W +: P_W]    = pos;
        assign oGapY[k*Y_W +: Y_W]   = gap;
        assign oActive[k]            = active;
        assign oRespawn[k]           = respawn;
    end

    assign oPass    = pass;
    assign oScore   = score;
    assign oRunning = running;

endmodule

// File: tb/tb_pipe_field_ctrl.sv
// tb/tb_pipe_field_ctrl.sv - directed vector bench for pipe_field_ctrl with a two-pipe field
module tb_pipe_field_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, run, spd;
    logic [7:0]  pos;
    logic [17:0] gap;
    logic [1:0]  active, respawn;
    logic        pass, running;
    logic [13:0] score;

    int total = 0;
    int bad   = 0;
    logic [15:0] lf, lf_prev;

    always #5 clk = ~clk;

    pipe_field_ctrl #(
        .N_PIPES(2), .START_POS(10), .SPACING(4), .END_POS(0), .BIRD_X(5),
        .START_SPEED(4), .MAX_SPEED(2), .SPEED_INC(1)
    ) dut (
        .iClk(clk), .iRstN(rst_n), .iStart(start), .iStop(stop), .iRun(run), .iSpeedInc(spd),
        .oPos(pos), .oGapY(gap), .oActive(active), .oRespawn(respawn), .oPass(pass),
        .oScore(score), .oRunning(running)
    );

    typedef struct {
        int cyc;
        int st;
        int p0;
        int p1;
        int act;
        int rn;
        int ps;
        int rsp;
        int sc;
        int gk;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input int cyc, input int st, input int p0, input int p1, input int act,
                                input int rn, input int ps, input int rsp, input int sc, input int gk);
        vec_t v;
        v.cyc = cyc; v.st = st; v.p0 = p0; v.p1 = p1; v.act = act;
        v.rn = rn; v.ps = ps; v.rsp = rsp; v.sc = sc; v.gk = gk;
        return v;
    endfunction

    function automatic logic [15:0] lf_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string name, input int act_v, input int exp_v);
        total++;
        if (act_v != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            lf_prev = lf;
            lf      = lf_next(lf);
            #1;
        end
    endtask

    task automatic chk_pos(input string name, input int p0, input int p1);
        chk({name, " pos0"}, int'(pos[3:0]), p0);
        chk({name, " pos1"}, int'(pos[7:4]), p1);
    endtask

    task automatic chk_gap(input string name, input int k);
        chk({name, " gap"}, int'(gap[k*9 +: 9]), 100 + int'(lf_prev[7:0]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; run = 1'b0; spd = 1'b0;
        lf = SEED; lf_prev = SEED;

        tbl[0]  = mk(1, 1, 10'd0, 0, 0, 0, 0, 0, 0, -1);
        tbl[0].p0 = 0;
        tbl[1]  = mk(1, 0, 10, 0,  1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 10, 14, 3, 0, 0, 0, 0, 1);
        tbl[3]  = mk(1, 0, 10, 14, 3, 1, 0, 0, 0, -1);
        tbl[4]  = mk(3, 0, 10, 14, 3, 1, 0, 0, 0, -1);
        tbl[5]  = mk(1, 0, 9,  13, 3, 1, 0, 0, 0, -1);
        tbl[6]  = mk(4, 0, 8,  12, 3, 1, 0, 0, 0, -1);
        tbl[7]  = mk(4, 0, 7,  11, 3, 1, 0, 0, 0, -1);
        tbl[8]  = mk(4, 0, 6,  10, 3, 1, 0, 0, 0, -1);
        tbl[9]  = mk(4, 0, 5,  9,  3, 1, 0, 0, 0, -1);
        tbl[10] = mk(4, 0, 4,  8,  3, 1, 1, 0, 1, -1);
        tbl[11] = mk(1, 0, 4,  8,  3, 1, 0, 0, 1, -1);
        tbl[12] = mk(3, 0, 3,  7,  3, 1, 0, 0, 1, -1);
        tbl[13] = mk(4, 0, 2,  6,  3, 1, 0, 0, 1, -1);
        tbl[14] = mk(4, 0, 1,  5,  3, 1, 0, 0, 1, -1);
        tbl[15] = mk(4, 0, 0,  4,  3, 1, 1, 0, 2, -1);
        tbl[16] = mk(4, 0, 8,  3,  3, 1, 0, 1, 2, 0);
        tbl[17] = mk(1, 0, 8,  3,  3, 1, 0, 0, 2, -1);

        repeat (3) @(posedge clk);
        #1;
        chk_pos("reset", 0, 0);
        chk("reset gap", int'(gap), 0);
        chk("reset active", int'(active), 0);
        chk("reset running", int'(running), 0);
        chk("reset score", int'(score), 0);
        rst_n = 1'b1;
        lf = SEED;
        step(2);
        chk("idle running", int'(running), 0);

        run = 1'b1;
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].st[0];
            step(1);
            start = 1'b0;
            if (tbl[i].cyc > 1) step(tbl[i].cyc - 1);
            chk_pos($sformatf("row%0d", i), tbl[i].p0, tbl[i].p1);
            chk($sformatf("row%0d active", i), int'(active), tbl[i].act);
            chk($sformatf("row%0d running", i), int'(running), tbl[i].rn);
            chk($sformatf("row%0d pass", i), int'(pass), tbl[i].ps);
            chk($sformatf("row%0d respawn", i), int'(respawn), tbl[i].rsp);
            chk($sformatf("row%0d score", i), int'(score), tbl[i].sc);
            if (tbl[i].gk >= 0) chk_gap($sformatf("row%0d", i), tbl[i].gk);
        end

        // Pause holds both positions and the tick counter
        run = 1'b0;
        step(20);
        chk_pos("pause", 8, 3);
        run = 1'b1;
        step(2);
        chk_pos("resume early", 8, 3);
        step(1);
        chk_pos("resume tick", 7, 2);

        // Speed-up 4 -> 3
        spd = 1'b1; step(1); spd = 1'b0;
        step(1);
        chk_pos("spd3 wait", 7, 2);
        step(1);
        chk_pos("spd3 tick", 6, 1);

        // Speed-up 3 -> 2 while cnt already past the new threshold
        step(1);
        spd = 1'b1; step(1); spd = 1'b0;
        chk_pos("spd2 wait", 6, 1);
        step(1);
        chk_pos("spd2 tick", 5, 0);

        // Speed-up at the floor stays at 2
        spd = 1'b1; step(1); spd = 1'b0;
        chk_pos("spdsat wait", 5, 0);
        step(1);
        chk_pos("spdsat tick", 4, 8);
        chk("spdsat pass", int'(pass), 1);
        chk("spdsat respawn", int'(respawn), 2);
        chk("spdsat score", int'(score), 3);
        chk_gap("spdsat", 1);
        step(1);
        chk_pos("spdsat hold", 4, 8);
        chk("spdsat pass low", int'(pass), 0);
        step(1);
        chk_pos("spdsat next", 3, 7);

        // Asynchronous reset mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk_pos("async rst", 0, 0);
        chk("async rst gap", int'(gap), 0);
        chk("async rst active", int'(active), 0);
        chk("async rst running", int'(running), 0);
        chk("async rst score", int'(score), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lf = SEED;
        step(2);

        // Start, load, run, then stop freezes everything
        start = 1'b1; step(1); start = 1'b0;
        chk("restart active", int'(active), 0);
        step(3);
        chk("restart running", int'(running), 1);
        chk_pos("restart", 10, 14);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("stop running", int'(running), 0);
        step(10);
        chk_pos("halt frozen", 10, 14);
        chk("halt active", int'(active), 3);

        // Start and stop together from RUN lands in HALT
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        chk("rerun running", int'(running), 1);
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        chk("both running", int'(running), 0);
        chk("both active", int'(active), 3);
        step(8);
        chk_pos("both frozen", 10, 14);
        chk("both still halted", int'(running), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_field_ctrl.md
# pipe_field_ctrl

Multi-channel obstacle field controller for SpacyBird, successor to the single-pipe position block. Scrolls `N_PIPES` pipes leftward at a shared, rampable speed, keeping a fixed horizontal spacing between them. On wrap it respawns each pipe with a pseudo-random gap height, and it raises a pass pulse plus a saturating score whenever a pipe crosses the bird column. Sits between the game FSM (start/stop/run/speed-up) and the renderer/collision logic (positions, gaps, active flags).

## Interface
- `N_PIPES`, 3: number of pipe channels (≥1).
- `H_TOT`, 800: horizontal total; informational, `START_POS` < `H_TOT` required.
- `RST_POS`, 0: position of every pipe after reset.
- `START_POS`, 640: load position of pipe 0; pipe k loads at `START_POS + k*SPACING`.
- `END_POS`, 0: wrap position.
- `SPACING`, 267: pixel distance between consecutive pipes (>0).
- `BIRD_X`, 100: bird column for pass detection (`END_POS` < `BIRD_X` ≤ `START_POS`).
- `GAP_MIN`, 100: minimum gap top Y.
- `GAP_BITS`, 8: random gap offset width; `GAP_MIN + 2^GAP_BITS - 1` < V total.
- `START_SPEED`, 800_000: initial clocks per 1-pixel move.
- `MAX_SPEED`, 100_000: smallest allowed period.
- `SPEED_INC`, 10_000: period decrement per speed-up request.
- `LFSR_SEED`, 16'hACE1: non-zero LFSR reset value.
- `SCORE_W`, 14: score width.
- Derived: `RESPAWN = END_POS + N_PIPES*SPACING`; `P_W = $clog2(max(START_POS+(N_PIPES-1)*SPACING, RESPAWN)+1)`; `S_W = $clog2(START_SPEED+1)`; `Y_W = $clog2(GAP_MIN + 2^GAP_BITS)`.

Ports:
- `iClk` in 1: single clock.
- `iRstN` in 1: reset, asynchronous, active-low.
- `iStart` in 1: start/restart pulse.
- `iStop` in 1: freeze pulse (game over).
- `iRun` in 1: movement enable (low = pause).
- `iSpeedInc` in 1: speed-up request pulse.
- `oPos` out `N_PIPES*P_W`: flattened positions; pipe k at `[k*P_W +: P_W]`.
- `oGapY` out `N_PIPES*Y_W`: flattened gap top Y.
- `oActive` out `N_PIPES`: pipe loaded and valid for drawing/collision.
- `oRespawn` out `N_PIPES`: one-cycle pulse when pipe k wraps.
- `oPass` out 1: one-cycle pulse when any pipe passes `BIRD_X`.
- `oScore` out `SCORE_W`: passes since start, saturating.
- `oRunning` out 1: state == RUN.

## Operation
- States: IDLE, LOAD, RUN, HALT.
- Priority each cycle is `iStop` > `iStart` > everything else.
- **IDLE → LOAD** on `iStart`. **RUN/HALT → LOAD** on `iStart` (restart).
- **RUN → HALT** on `iStop**. **LOAD → HALT** on `iStop`. In IDLE, `iStop` is ignored.
- **iStart actions:**
  - period ← `START_SPEED`; tick counter ← 0; score ← 0; load index ← 0; `oActive` ← 0.
- **LOAD (N_PIPES cycles):**
  - Cycle i writes pos[i] ← `START_POS + i*SPACING`, gap[i] ← `GAP_MIN + lfsr[GAP_BITS-1:0]`, active[i] ← 1.
  - After i = `N_PIPES-1` → RUN.
- **RUN, tick counter:** counts while `iRun` = 1.
  - tick = (`iRun` && cnt ≥ period-1). On tick, cnt ← 0; otherwise cnt ← cnt+1.
  - `iRun` = 0 holds cnt.
- **On tick, per active pipe k:**
  - If pos[k] == `END_POS`: pos[k] ← `RESPAWN`, gap[k] ← new random, `oRespawn[k]` pulses.
  - Otherwise pos[k] ← pos[k]-1.
  - If pos[k] == `BIRD_X` before the update, it counts as a pass.
- **Pass:** `oPass` pulses if any pipe passed. Score += number of passes, saturating at all-ones. At most one pipe can pass per tick because `SPACING` > 0.
- **Speed:** accepted in every state except the `iStart` cycle. period ← max(period - `SPEED_INC`, `MAX_SPEED`), computed without underflow.
- **LFSR:** free-running every cycle. Fibonacci, left shift, feedback = b15^b13^b12^b10, shifted into bit 0. Load and respawn sample the current LFSR value.
- **HALT:** positions, gaps, active flags and score are frozen; no ticks.

## Timing
- **Reset values:** state IDLE, all pos = `RST_POS`, gaps 0, `oActive` 0, `oRespawn` 0, `oPass` 0, `oScore` 0, `oRunning` 0, period `START_SPEED`, cnt 0, lfsr `LFSR_SEED`.
- All outputs are registered.
- **Load latency:** `oActive[i]` rises i+1 cycles after the `iStart` edge. `oRunning` rises `N_PIPES`+1 cycles after that edge.
- **Move timing:** with `iRun` held high, the first move lands at edge = period after RUN entry, then every period cycles. `oPos`, `oRespawn`, `oPass` and `oScore` update on the same edge.
- **Period change mid-count:** the ≥ compare makes the next tick fire immediately if cnt already exceeds the new period-1.
- **Asynchronous reset mid-LOAD or mid-RUN:** everything returns to reset values immediately.

## Structure
- **Package `pipe_pkg`:** state enum, LFSR tap mask and feedback function, `RESPAWN`/width helper functions.
- **Sub-module `pipe_lfsr16`:** seedable 16-bit LFSR with parameter `SEED`.
- Per-pipe logic is a generate loop inside `pipe_field_ctrl`.

## Test plan
- **Bench parameters (all scenarios):** `N_PIPES`=2, `START_POS`=10, `SPACING`=4, `END_POS`=0, `BIRD_X`=5, `START_SPEED`=4, `MAX_SPEED`=2, `SPEED_INC`=1.
- **Reset/load:** release `iRstN`, pulse `iStart` → `oPos`={0,0}, then pipe0=10 and active0 one cycle later, pipe1=14 and active1 the next cycle, `oRunning`=1 one cycle after that.
- **Scroll/pass:** `iRun`=1 → pipe0 decrements every 4 cycles. On the tick where pos0=5→4, `oPass`=1 for exactly one cycle and `oScore`=1.
- **Wrap:** continue until pos0=0 → next tick gives pos0=8, `oRespawn[0]`=1, pos1=3, gap0 = `GAP_MIN` + lfsr bits.
- **Speed:** 3 `iSpeedInc` pulses → period 3, 2, 2 (saturates). Also issue `iSpeedInc` with cnt=3 and period 4→3 → tick fires the next cycle.
- **Pause/stop:** `iRun`=0 for 20 cycles → no position change. `iStop` → HALT, values frozen. `iStart`+`iStop` together → HALT. `iRstN` low mid-RUN → all outputs return to reset values within the same cycle.
